// File: rtl/mul10_arb.sv
// rtl/mul10_arb.sv - two-requester arbiter sharing one registered 10x10 unsigned multiplier
// Optional zero bypass: define MUL10_ARB_ZBYP_EN to skip CALC when an operand is zero.
module mul10_arb #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [W-1:0]   x0,
  input  logic [W-1:0]   y0,
  output logic           ack0,
  input  logic           req1,
  input  logic [W-1:0]   x1,
  input  logic [W-1:0]   y1,
  output logic           ack1,
  output logic [2*W-1:0] z,
  output logic           z_id,
  output logic           z_valid,
  input  logic           z_ready
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   opa, opb;
  logic           gid;
  logic           last;
  logic           sel;
  logic [W-1:0]   sel_x, sel_y;
  logic           zero_hit;
  logic [2*W-1:0] prod;
  logic           do_grant, do_calc, do_bypass, do_accept;

  // Ties go to whoever did not win last time; a lone request wins outright.
  always_comb begin
    sel   = (req0 & req1) ? ~last : req1;
    sel_x = sel ? x1 : x0;
    sel_y = sel ? y1 : y0;
  end

`ifdef MUL10_ARB_ZBYP_EN
  assign zero_hit = (sel_x == '0) | (sel_y == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign prod = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 | req1) state_nx = zero_hit ? HOLD : CALC;
      CALC:    state_nx = HOLD;
      HOLD:    if (z_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_grant  = (state == IDLE) & (req0 | req1);
    do_bypass = do_grant & zero_hit;
    do_calc   = (state == CALC);
    do_accept = (state == HOLD) & z_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      gid     <= 1'b0;
      last    <= 1'b1;
      z       <= '0;
      z_id    <= 1'b0;
      z_valid <= 1'b0;
    end else begin
      ack0 <= do_grant & ~sel;
      ack1 <= do_grant & sel;
      if (do_grant) begin
        opa  <= sel_x;
        opb  <= sel_y;
        gid  <= sel;
        last <= sel;
      end
      if (do_calc) begin
        z       <= prod;
        z_id    <= gid;
        z_valid <= 1'b1;
      end else if (do_bypass) begin
        z       <= '0;
        z_id    <= sel;
        z_valid <= 1'b1;
      end else if (do_accept) begin
        z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul10_arb.sv
// tb/tb_mul10_arb.sv - scoreboard bench for mul10_arb
module tb_mul10_arb;
  localparam int W = 10;

`ifdef MUL10_ARB_ZBYP_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic           ack0, ack1;
  logic [2*W-1:0] z;
  logic           z_id, z_valid;
  logic           z_ready = 1'b1;

  typedef struct packed {
    logic           id;
    logic [2*W-1:0] z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  mul10_arb #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .x0(x0), .y0(y0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .ack1(ack1),
    .z(z), .z_id(z_id), .z_valid(z_valid), .z_ready(z_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(output bit ok, output logic id, output int t);
    ok = 0; id = 0; t = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        ok = 1; id = ack1; t = cyc;
      end
    end
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t n;
    n.id = id;
    n.z  = 20'(a) * 20'(b);
    sb.push_back(n);
  endtask

  task automatic test_reset;
    bit ok; logic id; int t;
    rst_n = 0; req0 = 1; x0 = 2; y0 = 3; req1 = 0; z_ready = 1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({ack0, ack1, z_valid, z_id, z} !== '0) begin
        bad++; $display("FAIL reset_outputs got=%h want=0", {ack0, ack1, z_valid, z_id, z});
      end
    end
    rst_n = 1;
    wait_ack(ok, id, t);
    total++;
    if (!ok || id !== 1'b0 || ack1 !== 1'b0) begin
      bad++; $display("FAIL reset_first_grant got ok=%0d id=%0d want ok=1 id=0", ok, id);
      return;
    end
    req0 = 0;
    push_exp(1'b0, x0, y0);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (z_valid !== 1'b1 || z_id !== e.id || z !== e.z) begin
      bad++; $display("FAIL reset_result got v=%0d id=%0d z=%0d want v=1 id=%0d z=%0d", z_valid, z_id, z, e.id, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; logic id; int t;
    x0 = 1023; y0 = 1023; req0 = 1;
    wait_ack(ok, id, t);
    total++;
    if (!ok || id !== 1'b0) begin
      bad++; $display("FAIL single_grant got ok=%0d id=%0d want ok=1 id=0", ok, id);
      return;
    end
    req0 = 0;
    push_exp(1'b0, x0, y0);
    total++;
    if (z_valid !== 1'b0) begin
      bad++; $display("FAIL single_early_valid got=%0d want=0", z_valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (z_valid !== 1'b1 || z_id !== e.id || z !== e.z) begin
      bad++; $display("FAIL single_result got v=%0d id=%0d z=%0d want v=1 id=%0d z=%0d", z_valid, z_id, z, e.id, e.z);
    end
    total++;
    if (z !== 20'd1046529) begin
      bad++; $display("FAIL single_max_product got=%0d want=1046529", z);
    end
    @(negedge clk);
    total++;
    if ({z_valid, ack0} !== 2'b00) begin
      bad++; $display("FAIL single_one_cycle got v=%0d ack0=%0d want 0 0", z_valid, ack0);
    end
  endtask

  task automatic test_round_robin;
    bit ok; logic id; int t; int tprev;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    x0 = 3; y0 = 5; x1 = 7; y1 = 9; z_ready = 1;
    req0 = 1; req1 = 1;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ok, id, t);
      total++;
      if (!ok || id !== k[0]) begin
        bad++; $display("FAIL rr_grant_order k=%0d got ok=%0d id=%0d want id=%0d", k, ok, id, k[0]);
        req0 = 0; req1 = 0;
        return;
      end
      if (id) push_exp(1'b1, x1, y1);
      else    push_exp(1'b0, x0, y0);
      if (k > 0) begin
        total++;
        if (t - tprev !== 3) begin
          bad++; $display("FAIL rr_spacing k=%0d got=%0d want=3", k, t - tprev);
        end
      end
      tprev = t;
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (z_valid !== 1'b1 || z_id !== e.id || z !== e.z) begin
        bad++; $display("FAIL rr_result k=%0d got v=%0d id=%0d z=%0d want v=1 id=%0d z=%0d", k, z_valid, z_id, z, e.id, e.z);
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok; logic id; int t;
    z_ready = 0; x1 = 512; y1 = 2; req1 = 1;
    wait_ack(ok, id, t);
    total++;
    if (!ok || id !== 1'b1) begin
      bad++; $display("FAIL bp_grant got ok=%0d id=%0d want ok=1 id=1", ok, id);
      req1 = 0; z_ready = 1;
      return;
    end
    req1 = 0;
    push_exp(1'b1, x1, y1);
    x0 = 4; y0 = 4; req0 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({z_valid, z_id, z, ack0, ack1} !== {1'b1, sb[0].id, sb[0].z, 2'b00}) begin
        bad++; $display("FAIL bp_hold i=%0d got v=%0d id=%0d z=%0d acks=%0d%0d want v=1 id=%0d z=%0d acks=00",
                        i, z_valid, z_id, z, ack0, ack1, sb[0].id, sb[0].z);
      end
    end
    void'(sb.pop_front());
    z_ready = 1;
    @(negedge clk);
    total++;
    if ({z_valid, ack0} !== 2'b00) begin
      bad++; $display("FAIL bp_after_accept got v=%0d ack0=%0d want 0 0", z_valid, ack0);
    end
    @(negedge clk);
    total++;
    if (ack0 !== 1'b1) begin
      bad++; $display("FAIL bp_next_grant got ack0=%0d want 1", ack0);
    end
    req0 = 0;
    push_exp(1'b0, x0, y0);
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (z_valid !== 1'b1 || z_id !== e.id || z !== e.z) begin
      bad++; $display("FAIL bp_followup got v=%0d id=%0d z=%0d want v=1 id=%0d z=%0d", z_valid, z_id, z, e.id, e.z);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc;
    bit ok; logic id; int t;
    x0 = 100; y0 = 10; req0 = 1;
    wait_ack(ok, id, t);
    total++;
    if (!ok || id !== 1'b0) begin
      bad++; $display("FAIL midrst_grant got ok=%0d id=%0d want ok=1 id=0", ok, id);
    end
    rst_n = 0; req0 = 0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({z_valid, ack0, ack1, z} !== '0) begin
        bad++; $display("FAIL midrst_discard got v=%0d acks=%0d%0d z=%0d want all 0", z_valid, ack0, ack1, z);
      end
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({z_valid, z} !== '0) begin
      bad++; $display("FAIL midrst_after got v=%0d z=%0d want 0 0", z_valid, z);
    end
  endtask

  task automatic test_zero_operand;
    bit ok; logic id; int t; int n;
    x1 = 9; y1 = 9; req1 = 1;
    wait_ack(ok, id, t);
    req1 = 0;
    @(negedge clk);
    @(negedge clk);
    x0 = 0; y0 = 777; req0 = 1;
    wait_ack(ok, id, t);
    total++;
    if (!ok || id !== 1'b0) begin
      bad++; $display("FAIL zero_grant got ok=%0d id=%0d want ok=1 id=0", ok, id);
      req0 = 0;
      return;
    end
    req0 = 0;
    push_exp(1'b0, x0, y0);
    n = 0;
    while (!z_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== ZLAT) begin
      bad++; $display("FAIL zero_latency got=%0d want=%0d", n, ZLAT);
    end
    e = sb.pop_front();
    total++;
    if (z_valid !== 1'b1 || z_id !== e.id || z !== e.z) begin
      bad++; $display("FAIL zero_result got v=%0d id=%0d z=%0d want v=1 id=%0d z=%0d", z_valid, z_id, z, e.id, e.z);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    test_zero_operand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
